branch_cmp_seq: RTL and testbench

Parametrised, multi-cycle branch-condition resolver for the RV32IC execute stage. Compares two XLEN-bit operands CHUNK bits per cycle, MSB-first, with early exit on the first differing chunk. Evaluates the six RISC-V branch conditions selected by func3 and returns a taken flag over a valid/ready handshake. It replaces the single-cycle combinational flag logic where area or timing favours a serial comparator.

---
 rtl/branch_cmp_seq_pkg.sv | 50 +++++
 rtl/branch_cmp_seq_chunk_cmp.sv | 27 ++
 rtl/branch_cmp_seq.sv | 167 ++++++++++++++++
 tb/tb_branch_cmp_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_cmp_seq_pkg.sv
// Shared definitions for the serial branch-condition resolver:
// func3 branch encodings, FSM state encoding and small decode helpers.
package branch_cmp_seq_pkg;

   // RV32I branch func3 encodings
   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   // Resolver FSM state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_e;

   // 010 and 011 are the only unused branch encodings
   function automatic logic is_illegal(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

   // BLT/BGE compare two's-complement operands
   function automatic logic is_signed_type(input logic [2:0] f3);
      return (f3 == BR_BLT) || (f3 == BR_BGE);
   endfunction

   // BEQ/BNE only need an equality result
   function automatic logic is_eq_type(input logic [2:0] f3);
      return (f3 == BR_BEQ) || (f3 == BR_BNE);
   endfunction

   // Map the comparison outcome onto the selected branch condition
   function automatic logic resolve_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt);
      logic t;
      case (f3)
         BR_BEQ:           t = eq;
         BR_BNE:           t = !eq;
         BR_BLT, BR_BLTU:  t = lt;
         BR_BGE, BR_BGEU:  t = !lt;
         default:          t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/branch_cmp_seq_chunk_cmp.sv
// branch_chunk_cmp: combinational CHUNK-bit magnitude/equality compare.
// sign_inv_i flips the MSB of both operands so that a two's-complement
// chunk orders correctly under an unsigned compare.
module branch_chunk_cmp #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             sign_inv_i,
   output logic             eq_o,
   output logic             lt_o
);

   localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

   logic [CHUNK-1:0] a_x;
   logic [CHUNK-1:0] b_x;

   // Bias the sign bit when comparing the top chunk of signed operands
   always_comb begin
      a_x  = a_i ^ (sign_inv_i ? MSB_MASK : '0);
      b_x  = b_i ^ (sign_inv_i ? MSB_MASK : '0);
      eq_o = (a_x == b_x);
      lt_o = (a_x < b_x);
   end

endmodule

// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: serial RISC-V branch-condition resolver.
// Compares rs1/rs2 CHUNK bits per cycle, MSB chunk first, stopping at the
// first differing chunk, and returns taken over a valid/ready handshake.
// Optional build macro BRANCH_CMP_FAST_EQ_EN: BEQ/BNE resolve with a
// full-width equality at acceptance and skip the serial compare.
module branch_cmp_seq
   import branch_cmp_seq_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            taken,
   output logic            illegal,
   output logic            busy
);

   localparam int N     = XLEN / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   // Operand width must split into whole chunks
   if ((XLEN % CHUNK) != 0) begin : g_bad_chunk
      $error("branch_cmp_seq: XLEN must be a multiple of CHUNK");
   end

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              taken_q, taken_d;
   logic              illegal_q, illegal_d;
   logic              out_valid_q, out_valid_d;

   // Latched request (datapath, not reset)
   logic [XLEN-1:0]   a_q;
   logic [XLEN-1:0]   b_q;
   logic [2:0]        f3_q;

   logic [CNT_W-1:0]  idx;
   logic              last_chunk;
   logic              top_chunk;
   logic [CHUNK-1:0]  a_chunk;
   logic [CHUNK-1:0]  b_chunk;
   logic              chunk_eq;
   logic              chunk_lt;
   logic              accept;

   assign accept   = (state_q == IDLE) && in_valid;
   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);

   assign out_valid = out_valid_q;
   assign taken     = taken_q;
   assign illegal   = illegal_q;

   // Capture operands and func3 on acceptance; later input changes are ignored
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= rs1;
         b_q  <= rs2;
         f3_q <= func3;
      end
   end

   // Select the chunk addressed by cnt, counting down from the MSB chunk
   always_comb begin
      idx        = CNT_W'(N - 1) - cnt_q;
      last_chunk = (cnt_q == CNT_W'(N - 1));
      top_chunk  = (cnt_q == '0);
      a_chunk    = '0;
      b_chunk    = '0;
      for (int i = 0; i < N; i++) begin
         if (idx == CNT_W'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   branch_chunk_cmp #(
      .CHUNK      (CHUNK)
   ) u_chunk_cmp (
      .a_i        (a_chunk),
      .b_i        (b_chunk),
      .sign_inv_i (is_signed_type(f3_q) && top_chunk),
      .eq_o       (chunk_eq),
      .lt_o       (chunk_lt)
   );

   // Next-state, counter and result decode for the resolver FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               cnt_d     = '0;
               illegal_d = is_illegal(func3);
               if (is_illegal(func3)) begin
                  taken_d = 1'b0;
                  state_d = DONE;
               end
`ifdef BRANCH_CMP_FAST_EQ_EN
               else if (is_eq_type(func3)) begin
                  taken_d = resolve_taken(func3, rs1 == rs2, 1'b0);
                  state_d = DONE;
               end
`endif
               else begin
                  state_d = CMP;
               end
            end
         end

         CMP: begin
            if (!chunk_eq) begin
               taken_d = resolve_taken(f3_q, 1'b0, chunk_lt);
               state_d = DONE;
            end else if (last_chunk) begin
               taken_d = resolve_taken(f3_q, 1'b1, 1'b0);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      out_valid_d = (state_d == DONE);
   end

   // Control and result registers; reset discards any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         taken_q     <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         taken_q     <= taken_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed bench for branch_cmp_seq (XLEN=32, CHUNK=8).
module tb_branch_cmp_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  func3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        out_valid;
   logic        out_ready;
   logic        taken;
   logic        illegal;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   branch_cmp_seq #(
      .XLEN      (32),
      .CHUNK     (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .func3     (func3),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .taken     (taken),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic        exp_taken;
      logic        exp_ill;
      int          exp_lat;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // BEQ/BNE take the single-cycle path when the fast equality build is used
   function automatic int adj_lat(input logic [2:0] f3, input int lat);
`ifdef BRANCH_CMP_FAST_EQ_EN
      if (f3 == 3'b000 || f3 == 3'b001) return 1;
`endif
      return lat;
   endfunction

   // Issue one request from a negedge; returns result and acceptance-to-valid latency.
   // Leaves out_ready low so the caller controls the output handshake.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic t, output logic il, output int lat);
      check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      func3     = f3;
      rs1       = a;
      rs2       = b;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      func3    = ~f3;
      rs1      = ~a;
      rs2      = a ^ b ^ 32'h5A5A_5A5A;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      t  = taken;
      il = illegal;
   endtask

   // Complete the output handshake and confirm the block is ready again
   task automatic finish_req(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({name, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic t;
      logic il;
      int   lat;
      bit   seen;

      vecs[0]  = '{"blt_neg_pos",     3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 2};
      vecs[1]  = '{"bltu_ff_01",      3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2};
      vecs[2]  = '{"bge_equal",       3'b101, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 5};
      vecs[3]  = '{"bne_last_chunk",  3'b001, 32'hA5A5_A500, 32'hA5A5_A501, 1'b1, 1'b0, adj_lat(3'b001, 5)};
      vecs[4]  = '{"beq_last_chunk",  3'b000, 32'hA5A5_A500, 32'hA5A5_A501, 1'b0, 1'b0, adj_lat(3'b000, 5)};
      vecs[5]  = '{"beq_equal",       3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, adj_lat(3'b000, 5)};
      vecs[6]  = '{"bgeu_chunk2",     3'b111, 32'h0001_0000, 32'h0002_0000, 1'b0, 1'b0, 3};
      vecs[7]  = '{"blt_min_max",     3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
      vecs[8]  = '{"bge_chunk1",      3'b101, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 4};
      vecs[9]  = '{"blt_neg_low",     3'b100, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 1'b0, 5};
      vecs[10] = '{"bltu_7f_80",      3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 2};
      vecs[11] = '{"illegal_011",     3'b011, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1};
      vecs[12] = '{"blt_equal",       3'b100, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 5};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      func3     = 3'b000;
      rs1       = '0;
      rs2       = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_taken",     {31'd0, taken},     32'd0);
      check("rst_illegal",   {31'd0, illegal},   32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, t, il, lat);
         check({vecs[i].name, "_taken"},   {31'd0, t},  {31'd0, vecs[i].exp_taken});
         check({vecs[i].name, "_illegal"}, {31'd0, il}, {31'd0, vecs[i].exp_ill});
         check({vecs[i].name, "_latency"}, lat,         vecs[i].exp_lat);
         finish_req(vecs[i].name);
      end

      // Illegal func3 with back-pressure: outputs hold while out_ready is low
      issue(3'b010, 32'hFFFF_FFFF, 32'h0, t, il, lat);
      check("bp_illegal", {31'd0, il}, 32'd1);
      check("bp_taken",   {31'd0, t},  32'd0);
      check("bp_latency", lat,         1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
         check("bp_taken_hold",     {31'd0, taken},     32'd0);
         check("bp_illegal_hold",   {31'd0, illegal},   32'd1);
         check("bp_in_ready_low",   {31'd0, in_ready},  32'd0);
      end
      finish_req("bp");

      // Leave taken=1 so the asynchronous reset clear is observable
      issue(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, t, il, lat);
      check("pre_rst_taken", {31'd0, t}, 32'd1);
      finish_req("pre_rst");

      // Reset asserted mid-compare with cnt=2
      check("mid_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      func3    = 3'b101;
      rs1      = 32'hCAFE_F00D;
      rs2      = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_in_ready",  {31'd0, in_ready},  32'd1);
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_taken",     {31'd0, taken},     32'd0);
      check("async_illegal",   {31'd0, illegal},   32'd0);
      check("async_busy",      {31'd0, busy},      32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("post_rst_no_out_valid", {31'd0, seen}, 32'd0);

      // A fresh request completes normally after reset
      issue(3'b110, 32'h7FFF_FFFF, 32'h8000_0000, t, il, lat);
      check("post_rst_taken",   {31'd0, t},  32'd1);
      check("post_rst_illegal", {31'd0, il}, 32'd0);
      check("post_rst_latency", lat,         2);
      finish_req("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
